ysyx_22040237_wbu_pipe: RTL and testbench

YSYX_22040237_WBU_PIPE -- requirements
Module: ysyx_22040237_wbu_pipe

---
 rtl/ysyx_22040237_wbu_pipe.sv | 142 ++++++++++++++
 tb/tb_ysyx_22040237_wbu_pipe.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040237_wbu_pipe.sv
// Writeback stage: load extraction/extension, rd write qualification, registered output beat.
// Define YSYX_22040237_WBU_SKID_EN for a one-entry skid buffer with a registered in_ready.
module ysyx_22040237_wbu_pipe #(
  parameter int REG_WIDTH = 64,
  parameter int RF_IDX_W  = 5,
  localparam int OFS_W    = $clog2(REG_WIDTH / 8)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 rd_wr_en_i,
  input  logic [RF_IDX_W-1:0]  rd_idx_i,
  input  logic [REG_WIDTH-1:0] alu_res_i,
  input  logic                 is_load_i,
  input  logic [1:0]           ld_size_i,
  input  logic                 ld_uns_i,
  input  logic [OFS_W-1:0]     ld_ofs_i,
  input  logic [REG_WIDTH-1:0] mem_rd_data_i,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 rd_wr_en_o,
  output logic [RF_IDX_W-1:0]  rd_idx_o,
  output logic [REG_WIDTH-1:0] rd_data_o,
  output logic                 misalign_o,
  output logic [63:0]          retire_cnt_o
);

  typedef struct packed {
    logic                 wen;
    logic [RF_IDX_W-1:0]  idx;
    logic [REG_WIDTH-1:0] data;
    logic                 mis;
  } beat_t;

  logic [REG_WIDTH-1:0] w_shift;
  logic [REG_WIDTH-1:0] w_ld;
  logic [1:0]           w_size;
  logic                 w_mis;
  beat_t                w_in;
  logic                 w_in_fire;
  logic                 w_out_fire;

  beat_t                r_out;
  logic                 r_out_valid;
  logic [63:0]          r_retire;

  always_comb begin
    w_shift = mem_rd_data_i >> {ld_ofs_i, 3'b000};
    // A 32-bit datapath has no dword load; fold it onto the word path.
    w_size  = (REG_WIDTH == 32 && ld_size_i == 2'd3) ? 2'd2 : ld_size_i;
    w_ld    = '0;
    w_mis   = 1'b0;
    case (w_size)
      2'd0: w_ld = ld_uns_i ? REG_WIDTH'(w_shift[7:0])  : REG_WIDTH'($signed(w_shift[7:0]));
      2'd1: begin
        w_ld  = ld_uns_i ? REG_WIDTH'(w_shift[15:0]) : REG_WIDTH'($signed(w_shift[15:0]));
        w_mis = ld_ofs_i[0];
      end
      2'd2: begin
        w_ld  = ld_uns_i ? REG_WIDTH'(w_shift[31:0]) : REG_WIDTH'($signed(w_shift[31:0]));
        w_mis = |ld_ofs_i[1:0];
      end
      default: begin
        w_ld  = w_shift;
        w_mis = |ld_ofs_i;
      end
    endcase
    w_in.mis  = is_load_i & w_mis;
    w_in.idx  = rd_idx_i;
    w_in.data = is_load_i ? w_ld : alu_res_i;
    w_in.wen  = rd_wr_en_i & (rd_idx_i != '0) & ~w_in.mis;
  end

  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = r_out_valid & out_ready;

`ifdef YSYX_22040237_WBU_SKID_EN
  beat_t r_skid;
  logic  r_skid_valid;
  logic  r_in_ready;

  assign in_ready = r_in_ready;

  // in_ready is precomputed from the next skid occupancy so out_ready never reaches it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out        <= '0;
      r_out_valid  <= 1'b0;
      r_skid       <= '0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else if (!r_out_valid || out_ready) begin
      if (r_skid_valid) begin
        r_out        <= r_skid;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
        r_in_ready   <= 1'b1;
      end else if (w_in_fire) begin
        r_out        <= w_in;
        r_out_valid  <= 1'b1;
      end else begin
        r_out_valid  <= 1'b0;
      end
    end else if (w_in_fire) begin
      r_skid       <= w_in;
      r_skid_valid <= 1'b1;
      r_in_ready   <= 1'b0;
    end
  end
`else
  assign in_ready = ~r_out_valid | out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else if (w_in_fire) begin
      r_out       <= w_in;
      r_out_valid <= 1'b1;
    end else if (w_out_fire) begin
      r_out_valid <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_retire <= '0;
    end else if (w_out_fire) begin
      r_retire <= r_retire + 64'd1;
    end
  end

  assign out_valid    = r_out_valid;
  assign rd_wr_en_o   = r_out_valid & r_out.wen;
  assign rd_idx_o     = r_out.idx;
  assign rd_data_o    = r_out.data;
  assign misalign_o   = r_out.mis;
  assign retire_cnt_o = r_retire;

endmodule

// File: tb/tb_ysyx_22040237_wbu_pipe.sv
// Randomized bench for ysyx_22040237_wbu_pipe against a queue-based reference model.
// Follows YSYX_22040237_WBU_SKID_EN for the expected in_ready behaviour.
module tb_ysyx_22040237_wbu_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        rd_wr_en_i;
  logic [4:0]  rd_idx_i;
  logic [63:0] alu_res_i;
  logic        is_load_i;
  logic [1:0]  ld_size_i;
  logic        ld_uns_i;
  logic [2:0]  ld_ofs_i;
  logic [63:0] mem_rd_data_i;
  logic        out_valid;
  logic        out_ready;
  logic        rd_wr_en_o;
  logic [4:0]  rd_idx_o;
  logic [63:0] rd_data_o;
  logic        misalign_o;
  logic [63:0] retire_cnt_o;

  ysyx_22040237_wbu_pipe #(.REG_WIDTH(64), .RF_IDX_W(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .rd_wr_en_i(rd_wr_en_i), .rd_idx_i(rd_idx_i), .alu_res_i(alu_res_i),
    .is_load_i(is_load_i), .ld_size_i(ld_size_i), .ld_uns_i(ld_uns_i),
    .ld_ofs_i(ld_ofs_i), .mem_rd_data_i(mem_rd_data_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .rd_wr_en_o(rd_wr_en_o), .rd_idx_o(rd_idx_o), .rd_data_o(rd_data_o),
    .misalign_o(misalign_o), .retire_cnt_o(retire_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic        wen;
    logic [4:0]  idx;
    logic [63:0] alu;
    logic        isl;
    logic [1:0]  size;
    logic        uns;
    logic [2:0]  ofs;
    logic [63:0] mem;
  } in_t;

  typedef struct {
    logic        wen;
    logic [4:0]  idx;
    logic [63:0] data;
    logic        mis;
  } exp_t;

  exp_t        q[$];
  logic [63:0] n_ret = '0;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input in_t b);
    exp_t        e;
    int          nb;
    logic [63:0] sh, mask, val;
    logic        mis;
    nb   = 1 << b.size;
    sh   = b.mem >> (8 * b.ofs);
    mask = (nb == 8) ? '1 : ((64'd1 << (8 * nb)) - 64'd1);
    val  = sh & mask;
    if (!b.uns && nb < 8 && val[8*nb-1]) val = val | ~mask;
    mis    = b.isl && ((b.ofs % nb) != 0);
    e.mis  = mis;
    e.idx  = b.idx;
    e.data = b.isl ? val : b.alu;
    e.wen  = b.wen && (b.idx != 0) && !mis;
    return e;
  endfunction

  function automatic in_t alu_b(input logic [4:0] idx, input logic [63:0] alu);
    in_t b;
    b = '{v: 1'b1, wen: 1'b1, idx: idx, alu: alu, isl: 1'b0, size: 2'd0, uns: 1'b0,
          ofs: 3'd0, mem: 64'd0};
    return b;
  endfunction

  function automatic in_t ld_b(input logic [4:0] idx, input logic [1:0] size, input logic uns,
                               input logic [2:0] ofs, input logic [63:0] mem);
    in_t b;
    b = '{v: 1'b1, wen: 1'b1, idx: idx, alu: 64'hDEAD, isl: 1'b1, size: size, uns: uns,
          ofs: ofs, mem: mem};
    return b;
  endfunction

  function automatic in_t idle_b();
    in_t b;
    b = alu_b(5'd0, 64'd0);
    b.v = 1'b0;
    b.wen = 1'b0;
    return b;
  endfunction

  function automatic in_t rand_b();
    in_t b;
    b.v    = ($urandom_range(0, 3) != 0);
    b.wen  = $urandom_range(0, 1);
    b.idx  = 5'($urandom);
    b.alu  = {$urandom, $urandom};
    b.isl  = $urandom_range(0, 1);
    b.size = 2'($urandom);
    b.uns  = $urandom_range(0, 1);
    b.ofs  = 3'($urandom);
    b.mem  = {$urandom, $urandom};
    return b;
  endfunction

  // One clock: drive at negedge, check against the model, update the model at posedge.
  task automatic cycle(input in_t b, input logic ordy);
    logic exp_ov, exp_ir;
    @(negedge clk);
    in_valid = b.v; rd_wr_en_i = b.wen; rd_idx_i = b.idx; alu_res_i = b.alu;
    is_load_i = b.isl; ld_size_i = b.size; ld_uns_i = b.uns; ld_ofs_i = b.ofs;
    mem_rd_data_i = b.mem; out_ready = ordy;
    #1;
    exp_ov = (q.size() != 0);
`ifdef YSYX_22040237_WBU_SKID_EN
    exp_ir = (q.size() < 2);
`else
    exp_ir = !exp_ov || ordy;
`endif
    check("out_valid", 64'(out_valid), 64'(exp_ov));
    check("in_ready", 64'(in_ready), 64'(exp_ir));
    check("retire_cnt", retire_cnt_o, n_ret);
    if (exp_ov) begin
      check("rd_idx", 64'(rd_idx_o), 64'(q[0].idx));
      check("rd_data", rd_data_o, q[0].data);
      check("rd_wr_en", 64'(rd_wr_en_o), 64'(q[0].wen));
      check("misalign", 64'(misalign_o), 64'(q[0].mis));
    end else begin
      check("rd_wr_en_idle", 64'(rd_wr_en_o), 64'd0);
    end
    @(posedge clk);
    if (exp_ov && ordy) begin
      void'(q.pop_front());
      n_ret = n_ret + 64'd1;
    end
    if (b.v && exp_ir) q.push_back(model(b));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_rd_wr_en", 64'(rd_wr_en_o), 64'd0);
    check("rst_rd_idx", 64'(rd_idx_o), 64'd0);
    check("rst_rd_data", rd_data_o, 64'd0);
    check("rst_misalign", 64'(misalign_o), 64'd0);
    check("rst_retire", retire_cnt_o, 64'd0);
    q.delete();
    n_ret = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    in_t b;
    logic ordy;
    rst = 1'b0;
    in_valid = 1'b0; rd_wr_en_i = 1'b0; rd_idx_i = '0; alu_res_i = '0; is_load_i = 1'b0;
    ld_size_i = '0; ld_uns_i = 1'b0; ld_ofs_i = '0; mem_rd_data_i = '0; out_ready = 1'b0;
    do_reset();

    // Simple ALU beat, then drain and observe the counter.
    cycle(alu_b(5'd5, 64'h1234), 1'b1);
    cycle(idle_b(), 1'b1);
    cycle(idle_b(), 1'b1);

    // Signed/unsigned byte load, misaligned half, rd=0 suppression.
    cycle(ld_b(5'd7, 2'd0, 1'b0, 3'd3, 64'h00000000_80FF7F00), 1'b1);
    cycle(ld_b(5'd7, 2'd0, 1'b1, 3'd3, 64'h00000000_80FF7F00), 1'b1);
    cycle(ld_b(5'd8, 2'd1, 1'b0, 3'd1, 64'h00000000_80FF7F00), 1'b1);
    cycle(alu_b(5'd0, 64'h55), 1'b1);
    cycle(ld_b(5'd9, 2'd3, 1'b0, 3'd0, 64'h8765_4321_0FED_CBA9), 1'b1);
    cycle(ld_b(5'd10, 2'd2, 1'b0, 3'd4, 64'h8765_4321_0FED_CBA9), 1'b1);
    cycle(idle_b(), 1'b1);
    cycle(idle_b(), 1'b1);

    // Output stall with two beats offered.
    cycle(alu_b(5'd1, 64'hA1), 1'b0);
    cycle(alu_b(5'd2, 64'hA2), 1'b0);
    cycle(alu_b(5'd3, 64'hA3), 1'b0);
    repeat (4) cycle(idle_b(), 1'b1);

    // Eight back-to-back beats, then reset during a stall.
    do_reset();
    for (int i = 0; i < 8; i++) cycle(alu_b(5'(i + 1), 64'(100 + i)), 1'b1);
    cycle(idle_b(), 1'b1);
    cycle(idle_b(), 1'b1);
    check("retire_after_8", retire_cnt_o, 64'd8);
    cycle(alu_b(5'd4, 64'hBEEF), 1'b0);
    cycle(alu_b(5'd6, 64'hCAFE), 1'b0);
    do_reset();
    cycle(idle_b(), 1'b1);

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      b = rand_b();
      ordy = ($urandom_range(0, 2) != 0);
      cycle(b, ordy);
    end
    repeat (3) cycle(idle_b(), 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
